// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO.
// Supports a registered-read mode and a first-word-fall-through mode.
// It has threshold status flags and sticky overflow/underflow error flags.
module param_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              overflow_reg;
    logic              underflow_reg;
    logic              overflow_next;
    logic              underflow_next;
    logic              wr_acc;
    logic              rd_acc;

    // Status flags are decoded directly from the registered count.
    assign full         = (count_reg == CW'(DEPTH));
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= CW'(AF_LEVEL));
    assign almost_empty = (count_reg <= CW'(AE_LEVEL));
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A full FIFO still accepts a read, and an empty FIFO still accepts a write.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Compute the next count and the next error flags.
    // A new error in the same cycle takes priority over clr_err.
    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        overflow_next  = (overflow_reg  & ~clr_err) | (wr_en & full);
        underflow_next = (underflow_reg & ~clr_err) | (rd_en & empty);
    end

    // Update the pointers, the count and the error flags.
    // All of this state clears immediately when rst is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // The storage array is not reset.
    // Rejected writes never touch it.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_reg] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is visible whenever the FIFO holds data.
            // Forcing the output to zero when empty keeps rd_data at 0 during reset.
            assign rd_data  = empty ? '0 : mem[rd_ptr_reg];
            assign rd_valid = ~empty;
        end else begin : g_registered
            logic [DATA_W-1:0] rd_data_reg;
            logic              rd_valid_reg;

            // Register the popped word.
            // rd_valid pulses for exactly the one cycle after the accepted read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_acc;
                    if (rd_acc) rd_data_reg <= mem[rd_ptr_reg];
                end
            end

            assign rd_data  = rd_data_reg;
            assign rd_valid = rd_valid_reg;
        end
    endgenerate

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, 2..256.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  DATA_W  write data.
REQ-010 SHALL have port rd_en  input  1  read/pop request.
REQ-011 SHALL have port rd_data  output  DATA_W  read data.
REQ-012 SHALL have port rd_valid  output  1  rd_data holds a valid word.
REQ-013 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  current stored word count.
REQ-015 SHALL have port overflow, underflow  output  1 each  sticky error flags.
REQ-016 SHALL have port clr_err  input  1  synchronous clear of overflow/underflow.

Function
REQ-017 SHALL accept a write iff wr_en=1 and full=0; accepted word stored at write pointer, pointer +1 modulo DEPTH.
REQ-018 SHALL accept a read iff rd_en=1 and empty=0; read pointer +1 modulo DEPTH.
REQ-019 SHALL keep pointers log2(DEPTH) bits wide, wrapping DEPTH-1 -> 0 with no gap or duplicate.
REQ-020 SHALL update count +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write.
REQ-021 SHALL derive full = (count==DEPTH), empty = (count==0), almost_full/almost_empty from count thresholds, all registered-count based, no extra latency.
REQ-022 SHALL, when full and both wr_en and rd_en are asserted, reject the write, accept the read, and set overflow.
REQ-023 SHALL, when empty and both are asserted, accept the write, reject the read, and set underflow; in FWFT=0, rd_valid stays 0 that cycle.
REQ-024 SHALL set overflow on any cycle with wr_en=1 and write rejected; set underflow on any cycle with rd_en=1 and read rejected; both hold until clr_err or rst.
REQ-025 SHALL give clr_err priority lower than a same-cycle new error: error in the clr_err cycle leaves flag set.
REQ-026 FWFT=0: on accepted read, rd_data SHALL present the popped word on the next rising edge and rd_valid SHALL pulse high for exactly that one cycle; rd_data holds last value otherwise.
REQ-027 FWFT=1: rd_data SHALL show the head word and rd_valid SHALL equal ~empty continuously; an accepted rd_en pops the head and the next word appears the following cycle.
REQ-028 FWFT=1: a word written into an empty FIFO SHALL appear on rd_data with rd_valid=1 one cycle after the write edge.
REQ-029 SHALL preserve strict first-in first-out ordering across all wrap-around cases.
REQ-030 SHALL never modify stored memory contents on rejected writes.

Reset
REQ-031 rst=1 SHALL immediately (without clk) clear pointers and count, force empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0, rd_data=0.
REQ-032 Memory array contents SHALL NOT require reset; reset mid-operation SHALL discard all stored words.
REQ-033 Deassertion of rst SHALL allow a write on the first subsequent rising edge.

Verification
REQ-034 Defaults, FWFT=0: write 0x01..0x10 (16 words) -> full=1, count=16, almost_full from count 14; 17th write -> rejected, overflow=1.
REQ-035 Read 16 words back -> rd_data 0x01..0x10 in order, each one cycle after rd_en, rd_valid single-cycle pulses; then empty=1; extra read -> underflow=1.
REQ-036 Wrap: write 10, read 10, write 16, read 16 -> order preserved, count returns to 0.
REQ-037 Simultaneous rd_en+wr_en at count=5 for 20 cycles -> count stays 5, no error flags, output stream matches input delayed by 5 words.
REQ-038 FWFT=1: write 0xA5 to empty FIFO -> rd_data=0xA5, rd_valid=1 next cycle without rd_en; rd_en one cycle -> rd_valid=0, empty=1.
REQ-039 Assert rst asynchronously between edges at count=7 with overflow=1 -> count=0, empty=1, overflow=0 before next clk edge; clr_err with concurrent rejected write keeps overflow=1.
